branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Consumer end of the branch-comparator interface in the pipelined RV32I core.
- Sits in EX alongside the comparator:
  - drives the comparator's `br_unsigned` select;
  - consumes `br_less`/`br_equal`;
  - decides the actual branch/jump outcome and checks it against the fetch-stage prediction.
- On a mispredict, issues a registered PC redirect and holds pipeline flush for a fixed number of cycles through a small FSM.

Parameters:
- FLUSH_CYCLES, 2, cycles flush stays asserted per mispredict, including the redirect cycle; legal range 1..15.
- XLEN, 32, datapath width.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous reset, active-high
- ex_valid  in  1  EX holds a valid instruction
- ex_stall  in  1  EX frozen this cycle
- ex_is_branch  in  1  conditional branch
- ex_is_jal  in  1  JAL
- ex_is_jalr  in  1  JALR
- ex_funct3  in  3  branch funct3
- ex_pc  in  XLEN  instruction PC
- ex_imm  in  XLEN  sign-extended immediate
- rs1_data  in  XLEN  JALR base
- br_less  in  1  from comparator
- br_equal  in  1  from comparator
- ex_pred_taken  in  1  fetch prediction
- ex_pred_target  in  XLEN  predicted target
- br_unsigned  out  1  to comparator
- ex_ready  out  1  unit can accept
- redirect_valid  out  1  PC redirect pulse
- redirect_pc  out  XLEN  corrected PC
- flush  out  1  squash IF/ID and ID/EX
- illegal_br  out  1  funct3 010/011 on a branch, one-cycle pulse

Behaviour:
- **Reset:** all registered outputs 0, state IDLE, counter 0. Reset in any state aborts the squash immediately, with no redirect.
- **`br_unsigned`:** only combinational output, equals `ex_funct3[1]`.
- **Accept condition:** `ex_valid & ex_ready & ~ex_stall & (ex_is_branch|ex_is_jal|ex_is_jalr)`.
- **Priority** when several type bits are high: jalr > jal > branch.
- **Taken by funct3:**
  - 000 `eq`; 001 `~eq`;
  - 100 and 110 `less`; 101 and 111 `~less`;
  - 010 and 011: not taken, `illegal_br` pulses the next cycle.
  - jal and jalr are always taken.
- **Targets:**
  - branch/jal target = `ex_pc + ex_imm`.
  - jalr target = `(rs1_data + ex_imm)` with bit0 cleared.
  - fallthrough = `ex_pc + 4`.
  - All arithmetic is modulo 2^XLEN; 0xFFFFFFFC + 4 wraps to 0.
- **Mispredict:**
  - `actual_taken != ex_pred_taken`, or
  - `actual_taken & (target != ex_pred_target)`.
  - Correct PC = target if taken, else fallthrough.
- **FSM:**
  - IDLE: `ex_ready=1`. Accept with mispredict -> REDIRECT. Correct prediction or non-accept -> stay; no outputs.
  - REDIRECT (1 cycle, the cycle after accept): `redirect_valid=1`, `redirect_pc` = correct PC, `flush=1`, `ex_ready=0`. Counter loads FLUSH_CYCLES-1. If FLUSH_CYCLES==1 -> IDLE, else -> SQUASH.
  - SQUASH: `flush=1`, `ex_ready=0`, `redirect_valid=0`. Counter decrements every cycle regardless of `ex_stall`; at 1 -> IDLE.
- **Outputs outside REDIRECT:** `redirect_pc` holds its last value.
- **Latency:** redirect visible exactly 1 cycle after accept.
- **Inputs ignored** while `ex_ready=0`.

Optional Feature:
- Macro: BRU_PERF_EN.
- Defined:
  - Adds outputs `perf_branches` [31:0] and `perf_mispredicts` [31:0].
  - Each increments on every accept / every mispredict, saturating at 0xFFFFFFFF.
  - Reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package `rv_pkg`:
  - funct3 branch constants (`F3_BEQ` .. `F3_BGEU`);
  - `bru_state_e` enum {IDLE, REDIRECT, SQUASH};
  - `XLEN`.
- One natural sub-module, `bru_outcome`: combinational taken/target/mispredict evaluation. The top holds the FSM, counters and output registers.

Test Plan:
- BEQ, `br_equal=1`, pred not taken, pc=0x100, imm=0x20 -> next cycle `redirect_valid=1`, `redirect_pc=0x120`; `flush` high 2 cycles; `ex_ready` low 2 cycles.
- BLTU, funct3=110 -> `br_unsigned=1` same cycle; `br_less=0`, pred not taken -> no redirect, no flush, `ex_ready` stays 1.
- JALR, rs1=0x1003, imm=0x4, pred taken to 0x1007 -> target 0x1006 mismatch -> `redirect_pc=0x1006`.
- BNE taken, pred taken with wrong target 0x200 vs 0x140 -> redirect to 0x140; a second branch presented during SQUASH is ignored.
- funct3=010 branch -> `illegal_br` pulse; treated not taken; pred taken -> redirect to pc+4. pc=0xFFFFFFFC gives `redirect_pc=0x0`.
- Reset asserted during SQUASH -> next cycle `flush=0`, `ex_ready=1`. With BRU_PERF_EN: after 3 accepts and 1 mispredict, `perf_branches=3`, `perf_mispredicts=1`.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I core definitions: branch funct3 encodings, branch-resolve FSM states, datapath width.
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    SQUASH   = 2'd2
  } bru_state_e;

  // funct3 values 010/011 are not defined for conditional branches.
  function automatic logic f3_is_illegal(input logic [2:0] f3);
    return (f3[2:1] == 2'b01);
  endfunction

endpackage

// File: rtl/bru_outcome.sv
// Combinational branch/jump evaluation: actual direction, target, corrected PC and mispredict flag.
module bru_outcome #(
  parameter int XLEN = 32
) (
  input  logic            is_branch_i,
  input  logic            is_jal_i,
  input  logic            is_jalr_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic            less_i,
  input  logic            equal_i,
  input  logic            pred_taken_i,
  input  logic [XLEN-1:0] pred_target_i,
  output logic            valid_o,
  output logic            taken_o,
  output logic            illegal_o,
  output logic [XLEN-1:0] correct_pc_o,
  output logic            mispredict_o
);
  import rv_pkg::*;

  logic [XLEN-1:0] pc_rel;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] fallthrough;
  logic [XLEN-1:0] target;

  assign pc_rel      = pc_i + imm_i;
  assign jalr_sum    = rs1_i + imm_i;
  assign fallthrough = pc_i + XLEN'(4);
  assign valid_o     = is_branch_i | is_jal_i | is_jalr_i;

  // jalr outranks jal, which outranks a conditional branch.
  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    target    = pc_rel;
    if (is_jalr_i) begin
      taken_o = 1'b1;
      target  = {jalr_sum[XLEN-1:1], 1'b0};
    end else if (is_jal_i) begin
      taken_o = 1'b1;
    end else if (is_branch_i) begin
      case (funct3_i)
        F3_BEQ:           taken_o = equal_i;
        F3_BNE:           taken_o = ~equal_i;
        F3_BLT, F3_BLTU:  taken_o = less_i;
        F3_BGE, F3_BGEU:  taken_o = ~less_i;
        default: begin
          taken_o   = 1'b0;
          illegal_o = f3_is_illegal(funct3_i);
        end
      endcase
    end
  end

  assign correct_pc_o = taken_o ? target : fallthrough;
  assign mispredict_o = (taken_o != pred_taken_i) |
                        (taken_o & (target != pred_target_i));

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: checks fetch prediction, issues registered redirect and timed flush.
// Optional BRU_PERF_EN adds saturating accept/mispredict counters.
module branch_resolve_unit #(
  parameter int FLUSH_CYCLES = 2,
  parameter int XLEN         = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic            ex_is_branch,
  input  logic            ex_is_jal,
  input  logic            ex_is_jalr,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            br_less,
  input  logic            br_equal,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            br_unsigned,
  output logic            ex_ready,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            illegal_br
`ifdef BRU_PERF_EN
 ,output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
`endif
);
  import rv_pkg::*;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  bru_state_e      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            illegal_q;

  logic            oc_valid;
  logic            oc_taken;
  logic            oc_illegal;
  logic [XLEN-1:0] oc_correct_pc;
  logic            oc_mispredict;
  logic            accept;

  bru_outcome #(.XLEN(XLEN)) u_outcome (
    .is_branch_i   (ex_is_branch),
    .is_jal_i      (ex_is_jal),
    .is_jalr_i     (ex_is_jalr),
    .funct3_i      (ex_funct3),
    .pc_i          (ex_pc),
    .imm_i         (ex_imm),
    .rs1_i         (rs1_data),
    .less_i        (br_less),
    .equal_i       (br_equal),
    .pred_taken_i  (ex_pred_taken),
    .pred_target_i (ex_pred_target),
    .valid_o       (oc_valid),
    .taken_o       (oc_taken),
    .illegal_o     (oc_illegal),
    .correct_pc_o  (oc_correct_pc),
    .mispredict_o  (oc_mispredict)
  );

  assign br_unsigned = ex_funct3[1];
  assign ex_ready    = (state_q == IDLE);
  assign accept      = ex_valid & ex_ready & ~ex_stall & oc_valid;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      IDLE: begin
        if (accept && oc_mispredict) begin
          state_d       = REDIRECT;
          redirect_pc_d = oc_correct_pc;
        end
      end
      REDIRECT: begin
        cnt_d   = FLUSH_LOAD;
        state_d = (FLUSH_CYCLES == 1) ? IDLE : SQUASH;
      end
      SQUASH: begin
        // Stall is deliberately ignored here: the squash window is fixed-length.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      redirect_pc_q <= '0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      redirect_pc_q <= redirect_pc_d;
      illegal_q     <= accept & oc_illegal;
    end
  end

  assign redirect_valid = (state_q == REDIRECT);
  assign flush          = (state_q != IDLE);
  assign redirect_pc    = redirect_pc_q;
  assign illegal_br     = illegal_q;

`ifdef BRU_PERF_EN
  logic [31:0] perf_br_q;
  logic [31:0] perf_mis_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      perf_br_q  <= '0;
      perf_mis_q <= '0;
    end else begin
      if (accept && (perf_br_q != '1)) begin
        perf_br_q <= perf_br_q + 32'd1;
      end
      if (accept && oc_mispredict && (perf_mis_q != '1)) begin
        perf_mis_q <= perf_mis_q + 32'd1;
      end
    end
  end

  assign perf_branches    = perf_br_q;
  assign perf_mispredicts = perf_mis_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed cases then randomized traffic vs a cycle model.
module tb_branch_resolve_unit;

  localparam int FLUSH = 2;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        ex_valid, ex_stall, ex_is_branch, ex_is_jal, ex_is_jalr;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc, ex_imm, rs1_data, ex_pred_target;
  logic        br_less, br_equal, ex_pred_taken;
  logic        br_unsigned, ex_ready, redirect_valid, flush, illegal_br;
  logic [31:0] redirect_pc;
`ifdef BRU_PERF_EN
  logic [31:0] perf_branches, perf_mispredicts;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // model state: remaining flush cycles, redirect flag, last corrected PC
  int          m_busy;
  bit          m_rv, m_ill;
  logic [31:0] m_pc;
  int unsigned m_br, m_mis;

  branch_resolve_unit #(.FLUSH_CYCLES(FLUSH), .XLEN(32)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .ex_valid       (ex_valid),
    .ex_stall       (ex_stall),
    .ex_is_branch   (ex_is_branch),
    .ex_is_jal      (ex_is_jal),
    .ex_is_jalr     (ex_is_jalr),
    .ex_funct3      (ex_funct3),
    .ex_pc          (ex_pc),
    .ex_imm         (ex_imm),
    .rs1_data       (rs1_data),
    .br_less        (br_less),
    .br_equal       (br_equal),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .br_unsigned    (br_unsigned),
    .ex_ready       (ex_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .illegal_br     (illegal_br)
`ifdef BRU_PERF_EN
   ,.perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void ref_outcome(output bit taken, output logic [31:0] tgt,
                                      output logic [31:0] cpc, output bit mis, output bit ill);
    taken = 0;
    ill   = 0;
    tgt   = ex_pc + ex_imm;
    if (ex_is_jalr) begin
      taken = 1;
      tgt   = (rs1_data + ex_imm) & 32'hFFFF_FFFE;
    end else if (ex_is_jal) begin
      taken = 1;
    end else if (ex_is_branch) begin
      case (int'(ex_funct3))
        0:       taken = br_equal;
        1:       taken = !br_equal;
        4, 6:    taken = br_less;
        5, 7:    taken = !br_less;
        default: ill = 1;
      endcase
    end
    cpc = taken ? tgt : ex_pc + 32'd4;
    mis = (taken != ex_pred_taken) || (taken && tgt != ex_pred_target);
  endfunction

  task automatic set_idle();
    ex_valid = 0; ex_stall = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
    ex_funct3 = 0; ex_pc = 0; ex_imm = 0; rs1_data = 0; br_less = 0; br_equal = 0;
    ex_pred_taken = 0; ex_pred_target = 0;
  endtask

  // Inputs are already driven (just after a negedge); runs one clock and checks outputs.
  task automatic step();
    bit tk, mis, ill, acc;
    logic [31:0] tgt, cpc;
    #1;
    check("br_unsigned", {31'd0, br_unsigned}, {31'd0, ex_funct3[1]});
    ref_outcome(tk, tgt, cpc, mis, ill);
    acc = ex_valid && (m_busy == 0) && !ex_stall && (ex_is_branch || ex_is_jal || ex_is_jalr);
    @(posedge i_clk);
    if (i_reset) begin
      m_busy = 0; m_rv = 0; m_ill = 0; m_pc = 0; m_br = 0; m_mis = 0;
    end else begin
      m_ill = acc && ill;
      if (acc) m_br++;
      if (acc && mis) m_mis++;
      if (m_busy > 0) begin
        m_busy--;
        m_rv = 0;
      end else if (acc && mis) begin
        m_busy = FLUSH;
        m_rv   = 1;
        m_pc   = cpc;
      end else begin
        m_rv = 0;
      end
    end
    @(negedge i_clk);
    check("ex_ready",       {31'd0, ex_ready},       {31'd0, m_busy == 0});
    check("flush",          {31'd0, flush},          {31'd0, m_busy > 0});
    check("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_rv});
    check("redirect_pc",    redirect_pc,             m_pc);
    check("illegal_br",     {31'd0, illegal_br},     {31'd0, m_ill});
`ifdef BRU_PERF_EN
    check("perf_branches",    perf_branches,    m_br);
    check("perf_mispredicts", perf_mispredicts, m_mis);
`endif
  endtask

  task automatic branch(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                        input bit eq, input bit lt, input bit pt, input logic [31:0] ptgt);
    set_idle();
    ex_valid = 1; ex_is_branch = 1; ex_funct3 = f3; ex_pc = pc; ex_imm = imm;
    br_equal = eq; br_less = lt; ex_pred_taken = pt; ex_pred_target = ptgt;
  endtask

  initial begin
    bit tk, mis, ill;
    logic [31:0] tgt, cpc;
    m_busy = 0; m_rv = 0; m_ill = 0; m_pc = 0; m_br = 0; m_mis = 0;
    set_idle();
    i_reset = 1;
    step();
    step();
    i_reset = 0;
    check("reset_ready", {31'd0, ex_ready}, 32'd1);
    check("reset_flush", {31'd0, flush}, 32'd0);

    // BEQ taken, predicted not taken
    branch(3'b000, 32'h100, 32'h20, 1, 0, 0, 32'h0);
    step();
    check("beq_rv", {31'd0, redirect_valid}, 32'd1);
    check("beq_pc", redirect_pc, 32'h120);
    check("beq_ready", {31'd0, ex_ready}, 32'd0);
    set_idle();
    step();
    check("beq_flush2", {31'd0, flush}, 32'd1);
    step();
    check("beq_flush_end", {31'd0, flush}, 32'd0);

    // BLTU not taken, correctly predicted
    branch(3'b110, 32'h300, 32'h40, 0, 0, 0, 32'h0);
    step();
    check("bltu_rv", {31'd0, redirect_valid}, 32'd0);
    check("bltu_ready", {31'd0, ex_ready}, 32'd1);

    // JALR target mismatch on bit0
    set_idle();
    ex_valid = 1; ex_is_jalr = 1; rs1_data = 32'h1003; ex_imm = 32'h4;
    ex_pred_taken = 1; ex_pred_target = 32'h1007;
    step();
    check("jalr_pc", redirect_pc, 32'h1006);
    set_idle();
    step();
    step();

    // BNE taken with wrong target, then branches while squashing are ignored
    branch(3'b001, 32'h100, 32'h40, 0, 0, 1, 32'h200);
    step();
    check("bne_pc", redirect_pc, 32'h140);
    branch(3'b000, 32'h800, 32'h10, 1, 0, 0, 32'h0);
    step();
    step();
    check("bne_ignored_pc", redirect_pc, 32'h140);
    check("bne_ready", {31'd0, ex_ready}, 32'd1);
    set_idle();
    step();
    check("bne_no_rv", {31'd0, redirect_valid}, 32'd0);

    // illegal funct3, predicted taken, fallthrough wraps
    branch(3'b010, 32'hFFFF_FFFC, 32'h10, 1, 1, 1, 32'h10);
    step();
    check("ill_pulse", {31'd0, illegal_br}, 32'd1);
    check("ill_pc", redirect_pc, 32'h0);
    set_idle();
    step();
    check("ill_pulse_end", {31'd0, illegal_br}, 32'd0);
    step();

    // reset during SQUASH
    branch(3'b101, 32'h40, 32'h8, 0, 1, 1, 32'h48);
    step();
    set_idle();
    step();
    check("sq_flush", {31'd0, flush}, 32'd1);
    i_reset = 1;
    step();
    i_reset = 0;
    check("rst_sq_flush", {31'd0, flush}, 32'd0);
    check("rst_sq_ready", {31'd0, ex_ready}, 32'd1);

    // two correct predictions then one mispredict
    branch(3'b000, 32'h10, 32'h8, 0, 0, 0, 32'h0);
    step();
    branch(3'b111, 32'h20, 32'h8, 0, 1, 0, 32'h0);
    step();
    branch(3'b100, 32'h30, 32'h8, 0, 1, 0, 32'h0);
    step();
`ifdef BRU_PERF_EN
    check("perf_br3",  perf_branches,    32'd3);
    check("perf_mis1", perf_mispredicts, 32'd1);
`endif
    set_idle();
    step();
    step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      i_reset       = ($urandom_range(0, 99) == 0);
      ex_valid      = ($urandom_range(0, 7) != 0);
      ex_stall      = ($urandom_range(0, 7) == 0);
      ex_is_branch  = $urandom_range(0, 1);
      ex_is_jal     = ($urandom_range(0, 4) == 0);
      ex_is_jalr    = ($urandom_range(0, 4) == 0);
      ex_funct3     = 3'($urandom_range(0, 7));
      ex_pc         = $urandom & 32'hFFFF_FFFC;
      ex_imm        = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255)) - 32'd128;
      rs1_data      = $urandom;
      br_less       = $urandom_range(0, 1);
      br_equal      = $urandom_range(0, 1);
      ex_pred_taken = $urandom_range(0, 1);
      ex_pred_target = $urandom;
      ref_outcome(tk, tgt, cpc, mis, ill);
      if ($urandom_range(0, 1) == 1) ex_pred_target = tgt;
      step();
    end
    i_reset = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
